// File: rtl/id_scan_arb.sv
// Two-requester round-robin arbiter feeding a letters-then-digits string recognizer.
// One string is scanned at a time. Each string ends with a one-cycle result report.
module id_scan_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_char0,
    input  logic [7:0] req_char1,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    output logic       busy,
    output logic       grant_id,
    output logic       done,
    output logic       done_id,
    output logic       match,
    output logic [7:0] hit_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
    typedef enum logic [1:0] {R_NONE, R_ALPHA, R_DIGIT} rec_t;

    state_t     state_q, state_d;
    rec_t       rec_q, rec_d, rec_nxt;
    logic [7:0] cnt_q, cnt_d, cnt_nxt;
    logic       ptr_q, ptr_d;
    logic       grant_q, grant_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic       match_q, match_d;
    logic [7:0] hit_q, hit_d;
    logic       busy_q, busy_d;
    logic [1:0] ready_q, ready_d;

    logic [7:0] sel_char;
    logic       is_letter, is_num, accept;

    always_comb begin
        sel_char  = grant_q ? req_char1 : req_char0;
        is_letter = (sel_char >= 8'h41 && sel_char <= 8'h5A) ||
                    (sel_char >= 8'h61 && sel_char <= 8'h7A);
        is_num    = (sel_char >= 8'h30 && sel_char <= 8'h39);

        rec_nxt = R_NONE;
        case (rec_q)
            R_ALPHA, R_DIGIT: rec_nxt = is_letter ? R_ALPHA : (is_num ? R_DIGIT : R_NONE);
            default:          rec_nxt = is_letter ? R_ALPHA : R_NONE;
        endcase
        cnt_nxt = (rec_nxt == R_DIGIT && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

        accept = (state_q == SCAN) && req_valid[grant_q];

        state_d   = state_q;
        rec_d     = rec_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        match_d   = match_q;
        hit_d     = hit_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Single requester wins outright; on a tie the pointer decides.
                    grant_d = (&req_valid) ? ptr_q : req_valid[1];
                    state_d = SCAN;
                    rec_d   = R_NONE;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (accept) begin
                    rec_d = rec_nxt;
                    cnt_d = cnt_nxt;
                    if (req_last[grant_q]) begin
                        // Result is latched here so it is already on the outputs in REPORT.
                        state_d   = REPORT;
                        done_d    = 1'b1;
                        done_id_d = grant_q;
                        match_d   = (rec_nxt == R_DIGIT);
                        hit_d     = cnt_nxt;
                        ptr_d     = ~grant_q;
                    end
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == SCAN) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rec_q     <= R_NONE;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            grant_q   <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            match_q   <= 1'b0;
            hit_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= '0;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            match_q   <= match_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match     = match_q;
    assign hit_cnt   = hit_q;

endmodule
